mux_four_arbiter: RTL
=====================

# mux_four_arbiter

Four-requester round-robin arbiter that shares one resource whose input is selected by a 4:1 multiplexer (e.g., a single-ported memory shared by fetch, load/store and debug paths). It accepts level requests, issues one non-preemptive grant at a time for a fixed occupancy of LAT cycles, and drives the 2-bit mux select and a one-hot grant. It sits between the requesting pipeline stages and the shared resource's input mux.

## Interface
- LAT, 1: cycles each granted access occupies the resource; legal range 1..15.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  4  level request per requester, bit i = requester i; held until its done pulse.
- sel  out  2  mux select = index of the current/last granted requester.
- gnt  out  4  one-hot grant; all-zero when idle.
- done  out  4  one-hot pulse on the final cycle of an access; equals gnt in that cycle.
- busy  out  1  high while any grant is active.

## Operation
- State machine with two states and registered outputs.
  - IDLE: gnt = 0, busy = 0, sel holds its last value.
  - BUSY: gnt, sel and busy are held constant for exactly LAT cycles.
- Internal registers:
  - 2-bit round-robin pointer ptr.
  - 4-bit down-counter cnt.
  - 2-bit granted index idx, which drives sel.
- Arbitration is evaluated in IDLE, and in the final (done) cycle of BUSY.
  - Winner = first requester with req set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On a win: idx <= winner, gnt <= onehot(winner), cnt <= LAT-1, state <= BUSY.
- In BUSY: while cnt != 0, decrement cnt. When cnt == 0, done = gnt (combinational from the state registers).
- End of access, on the done cycle:
  - ptr <= idx+1 (mod 4), so the served requester gets the lowest priority.
  - The served requester's req bit is masked from that cycle's arbitration.
  - If any other req is set, the next grant starts on the following cycle with no bubble. Otherwise state <= IDLE.
- Non-preemptive: deasserting req during an access is ignored and the access runs to completion.
- Exactly one gnt bit is set in BUSY. done is never set outside BUSY.
- Reset values: state IDLE, gnt 0, done 0, busy 0, sel 2'b00, ptr 0, cnt 0, idx 0.
  - rst asserted mid-access aborts it: no done pulse is issued, and all registers take their reset values on that edge.
- LAT = 1: every grant lasts one cycle and done coincides with gnt. Under continuous multi-requester load, grants rotate one per cycle.

## Timing
- Request sampled at rising edge t (IDLE): gnt/sel/busy valid during cycles t+1 .. t+LAT; done valid in cycle t+LAT.
- Back-to-back: the next grant is valid in cycle t+LAT+1 if another requester was pending in cycle t+LAT.
- Same requester re-requesting continuously with no competition:
  - One IDLE cycle between its accesses, caused by the done-cycle mask.
  - Period is LAT+1 cycles.
- Simultaneous requests: resolved purely by ptr order; there is no fixed priority after reset except ptr = 0.
- Throughput ceiling: one completed access per LAT cycles under multi-requester load.

## Test plan
- Reset, then idle: hold rst 2 cycles with req=4'b1111.
  - Required during rst: gnt=0, done=0, busy=0, sel=00.
  - First cycle after rst release: still gnt=0. Next cycle: gnt=0001, sel=00.
- Round robin, LAT=2, req=4'b1111 held:
  - Grant order 0,1,2,3,0, each 2 cycles, no gaps.
  - done pulses in cycles 2,4,6,8.
  - sel sequence 00,00,01,01,10,10,11,11.
- Fairness after service, LAT=1, ptr=2, req=4'b0101:
  - Grant 2 first, then 0, then 2.
  - Requester 3 asserted mid-sequence is served before 0 if ptr points to 3.
- Single requester repeat, LAT=3, req=4'b1000 held:
  - gnt=1000 for 3 cycles, 1 idle cycle, repeat.
  - done asserted every 4th cycle; sel stays 11.
- Withdrawal and abort, LAT=4:
  - Drop req[1] in the 2nd grant cycle: gnt=0010 still lasts 4 cycles and done[1] pulses.
  - Assert rst in the 2nd cycle of the next grant: outputs are reset values next cycle, with no done pulse.
- LAT=1 single-cycle check, req=4'b0110 for one cycle only:
  - gnt=0010 with done=0010 in the same cycle.
  - Then gnt=0100/done=0100 only if req[2] is still held; else return to IDLE.

Source files
------------

// File: rtl/mux_four_arbiter_if.sv
// Bus between four requesting stages and the shared-resource arbiter.
//   req  : level request per requester (bit i = requester i)
//   sel  : 4:1 mux select, index of the current/last granted requester
//   gnt  : one-hot grant, all-zero when idle
//   done : one-hot pulse on the final cycle of an access
//   busy : high while a grant is active
// Modports: master = requesting side, slave = arbiter side.
interface mux_four_arbiter_if;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       busy;

  modport master (
    output req,
    input  sel,
    input  gnt,
    input  done,
    input  busy
  );

  modport slave (
    input  req,
    output sel,
    output gnt,
    output done,
    output busy
  );
endinterface

// File: rtl/mux_four_arbiter.sv
// Four-requester round-robin arbiter for a resource fed through a 4:1 mux.
// Each grant is non-preemptive and occupies the resource for LAT cycles.
//   LAT    : cycles per access, 1..15
//   i_clk  : rising-edge clock
//   i_rst  : synchronous active-high reset
//   io_bus : slave side of mux_four_arbiter_if (req in; sel/gnt/done/busy out)
module mux_four_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mux_four_arbiter_if.slave   io_bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  state_e     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [1:0] r_idx;
  logic [3:0] r_gnt;

  state_e     w_state_nxt;
  logic [1:0] w_ptr_nxt;
  logic [3:0] w_cnt_nxt;
  logic [1:0] w_idx_nxt;
  logic [3:0] w_gnt_nxt;

  logic       w_last;
  logic       w_arb_en;
  logic [3:0] w_req_m;
  logic [7:0] w_rot8;
  logic [3:0] w_rot;
  logic       w_found;
  logic [1:0] w_off;
  logic [1:0] w_win;

  // Final cycle of an access: done fires and arbitration runs again.
  assign w_last   = (r_state == StBusy) && (r_cnt == 4'd0);
  assign w_arb_en = (r_state == StIdle) || w_last;

  // The requester finishing this cycle must not win again immediately.
  assign w_req_m = io_bus.req & ~(w_last ? r_gnt : 4'b0000);

  // Rotate so that bit 0 corresponds to the requester at ptr.
  assign w_rot8  = {w_req_m, w_req_m} >> r_ptr;
  assign w_rot   = w_rot8[3:0];
  assign w_found = |w_rot;

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0]) begin
      w_off = 2'd0;
    end else if (w_rot[1]) begin
      w_off = 2'd1;
    end else if (w_rot[2]) begin
      w_off = 2'd2;
    end
  end

  assign w_win = r_ptr + w_off;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_gnt_nxt   = r_gnt;

    if ((r_state == StBusy) && (r_cnt != 4'd0)) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end

    if (w_last) begin
      w_ptr_nxt   = r_idx + 2'd1;
      w_state_nxt = StIdle;
      w_gnt_nxt   = 4'b0000;
    end

    // A new win overrides the end-of-access defaults, giving no bubble.
    if (w_arb_en && w_found) begin
      w_state_nxt = StBusy;
      w_idx_nxt   = w_win;
      w_gnt_nxt   = 4'b0001 << w_win;
      w_cnt_nxt   = CntInit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
      r_idx   <= 2'd0;
      r_gnt   <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign io_bus.sel  = r_idx;
  assign io_bus.gnt  = r_gnt;
  assign io_bus.busy = (r_state == StBusy);
  assign io_bus.done = w_last ? r_gnt : 4'b0000;

endmodule
